// File: rtl/ascon_aead_core.sv
// Ascon-AEAD128 engine: 320-bit state, UNROLL-round permutation, streaming AD/text blocks.
// Optional tag check in hardware when ASCON_TAG_VERIFY_EN is defined.
module ascon_aead_core #(
    parameter int unsigned UNROLL = 1,
    parameter logic [63:0] IV     = 64'h00001000808c0001
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         dec,
    input  logic         has_ad,
    input  logic         has_text,
    input  logic [127:0] key,
    input  logic [127:0] nonce,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    input  logic [127:0] tag_in,
    output logic [127:0] tag,
    output logic         tag_ok,
    output logic         done,
    output logic         busy
);

    localparam logic [3:0] Step = 4'(UNROLL);

    typedef enum logic [3:0] {
        StIdle,
        StInit,
        StAdWait,
        StAdPerm,
        StAdPad,
        StDsep,
        StTxtWait,
        StTxtPerm,
        StTxtPad,
        StFinal,
        StDone
    } state_e;

    state_e       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [319:0] s_q, s_d;
    logic         dec_q, dec_d;
    logic         has_ad_q, has_ad_d;
    logic         has_text_q, has_text_d;
    logic         last_q, last_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] out_data_q, out_data_d;
    logic [127:0] tag_q, tag_d;
    logic         tag_ok_q, tag_ok_d;

    logic [319:0] perm_in, perm_out;
    logic [3:0]   rc_base;
    logic [127:0] txt_x;
    logic [127:0] tag_calc;

    function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One Ascon round on {S4,S3,S2,S1,S0}; idx selects the round constant.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] idx);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[63:0];
        x1 = s[127:64];
        x2 = s[191:128];
        x3 = s[255:192];
        x4 = s[319:256];
        x2 = x2 ^ {56'd0, 8'hf0 - (8'(idx) * 8'h0f)};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1) ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7) ^ ror(x4, 41);
        return {x4, x3, x2, x1, x0};
    endfunction

    // Padding and key injection fold into the first round of their permutation.
    always_comb begin : perm_prep
        perm_in = s_q;
        rc_base = rnd_q;
        case (state_q)
            StAdPerm, StTxtPerm: rc_base = rnd_q + 4'd4;
            StAdPad: begin
                rc_base = rnd_q + 4'd4;
                if (rnd_q == 4'd0) perm_in[0] = ~s_q[0];
            end
            StFinal: begin
                if (rnd_q == 4'd0) perm_in[255:128] = s_q[255:128] ^ key;
            end
            default: ;
        endcase
    end

    always_comb begin : perm_core
        perm_out = perm_in;
        for (int unsigned j = 0; j < UNROLL; j++) begin
            perm_out = ascon_round(perm_out, rc_base + 4'(j));
        end
    end

    always_comb begin : fsm
        state_d     = state_q;
        rnd_d       = rnd_q;
        s_d         = s_q;
        dec_d       = dec_q;
        has_ad_d    = has_ad_q;
        has_text_d  = has_text_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        tag_d       = tag_q;
        tag_ok_d    = tag_ok_q;
        in_ready    = 1'b0;
        txt_x       = s_q[127:0] ^ in_data;
        tag_calc    = perm_out[319:192] ^ key;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    s_d        = {nonce, key, IV};
                    dec_d      = dec;
                    has_ad_d   = has_ad;
                    has_text_d = has_text;
                    rnd_d      = 4'd0;
                    state_d    = StInit;
                end
            end
            StInit: begin
                if (rnd_q == 4'd12) begin
                    s_d[319:192] = s_q[319:192] ^ key;
                    rnd_d        = 4'd0;
                    state_d      = has_ad_q ? StAdWait : StDsep;
                end else begin
                    s_d   = perm_out;
                    rnd_d = rnd_q + Step;
                end
            end
            StAdWait: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    s_d[127:0] = txt_x;
                    last_d     = in_last;
                    state_d    = StAdPerm;
                end
            end
            StAdPerm, StAdPad, StTxtPerm: begin
                s_d = perm_out;
                if (rnd_q + Step == 4'd8) begin
                    rnd_d = 4'd0;
                    if (state_q == StAdPerm) state_d = last_q ? StAdPad : StAdWait;
                    else if (state_q == StAdPad) state_d = StDsep;
                    else state_d = StTxtWait;
                end else begin
                    rnd_d = rnd_q + Step;
                end
            end
            StDsep: begin
                s_d[319] = ~s_q[319];
                state_d  = has_text_q ? StTxtWait : StTxtPad;
            end
            StTxtWait: begin
                in_ready = !out_valid_q || out_ready;
                if (in_valid && in_ready) begin
                    out_data_d  = txt_x;
                    out_valid_d = 1'b1;
                    s_d[127:0]  = dec_q ? in_data : txt_x;
                    state_d     = in_last ? StTxtPad : StTxtPerm;
                end
            end
            StTxtPad: begin
                s_d[0]  = ~s_q[0];
                state_d = StFinal;
            end
            StFinal: begin
                s_d = perm_out;
                if (rnd_q + Step == 4'd12) begin
                    rnd_d   = 4'd0;
                    state_d = StDone;
`ifdef ASCON_TAG_VERIFY_EN
                    tag_ok_d = dec_q && (tag_calc == tag_in);
                    tag_d    = (dec_q && (tag_calc != tag_in)) ? '0 : tag_calc;
`else
                    tag_ok_d = 1'b0;
                    tag_d    = tag_calc;
`endif
                end else begin
                    rnd_d = rnd_q + Step;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

`ifndef ASCON_TAG_VERIFY_EN
    logic unused_tag_in;
    assign unused_tag_in = ^tag_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rnd_q       <= '0;
            s_q         <= '0;
            dec_q       <= 1'b0;
            has_ad_q    <= 1'b0;
            has_text_q  <= 1'b0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            tag_q       <= '0;
            tag_ok_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            s_q         <= s_d;
            dec_q       <= dec_d;
            has_ad_q    <= has_ad_d;
            has_text_q  <= has_text_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            tag_q       <= tag_d;
            tag_ok_q    <= tag_ok_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign tag       = tag_q;
    assign tag_ok    = tag_ok_q;
    assign done      = (state_q == StDone);
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ascon_aead_core.sv
// Bench for ascon_aead_core: behavioural Ascon model (table S-box, lane arrays) vs DUT.
module tb_ascon_aead_core;

    localparam int unsigned UNROLL = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start, dec, has_ad, has_text;
    logic [127:0] key, nonce, in_data, out_data, tag_in, tag;
    logic         in_valid, in_ready, in_last, out_valid, out_ready, tag_ok, done, busy;

    always #5 clk = ~clk;

    ascon_aead_core #(.UNROLL(UNROLL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dec(dec), .has_ad(has_ad),
        .has_text(has_text), .key(key), .nonce(nonce), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .tag_in(tag_in), .tag(tag),
        .tag_ok(tag_ok), .done(done), .busy(busy)
    );

    int n_assert = 0;
    int n_fail = 0;

    logic [127:0] key_m, nonce_m, exp_tag;
    logic [127:0] blk_ad [8];
    logic [127:0] blk_tx [8];
    logic [127:0] exp_out [8];
    logic [63:0]  st [5];
    logic [127:0] got_q [$];

    logic [127:0] r_tag;
    bit           r_tag_ok, r_tmo;
    int           r_lat, r_stall_err;

    always @(negedge clk) if (rst_n && out_valid && out_ready) got_q.push_back(out_data);

    // ---------------- reference model ----------------
    function automatic logic [4:0] sbox(input logic [4:0] x);
        case (x)
            5'd0: return 5'h04;  5'd1: return 5'h0b;  5'd2: return 5'h1f;  5'd3: return 5'h14;
            5'd4: return 5'h1a;  5'd5: return 5'h15;  5'd6: return 5'h09;  5'd7: return 5'h02;
            5'd8: return 5'h1b;  5'd9: return 5'h05;  5'd10: return 5'h08; 5'd11: return 5'h12;
            5'd12: return 5'h1d; 5'd13: return 5'h03; 5'd14: return 5'h06; 5'd15: return 5'h1c;
            5'd16: return 5'h1e; 5'd17: return 5'h13; 5'd18: return 5'h07; 5'd19: return 5'h0e;
            5'd20: return 5'h00; 5'd21: return 5'h0d; 5'd22: return 5'h11; 5'd23: return 5'h18;
            5'd24: return 5'h10; 5'd25: return 5'h0c; 5'd26: return 5'h01; 5'd27: return 5'h19;
            5'd28: return 5'h16; 5'd29: return 5'h0a; 5'd30: return 5'h0f; default: return 5'h17;
        endcase
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    task automatic permute(input int rounds);
        logic [4:0] v, o;
        logic [63:0] t;
        int ra [5][2];
        ra = '{'{19, 28}, '{61, 39}, '{1, 6}, '{10, 17}, '{7, 41}};
        for (int r = 12 - rounds; r < 12; r++) begin
            st[2] = st[2] ^ 64'(((15 - r) << 4) | r);
            for (int b = 0; b < 64; b++) begin
                v = {st[0][b], st[1][b], st[2][b], st[3][b], st[4][b]};
                o = sbox(v);
                st[0][b] = o[4]; st[1][b] = o[3]; st[2][b] = o[2]; st[3][b] = o[1]; st[4][b] = o[0];
            end
            for (int i = 0; i < 5; i++) begin
                t = st[i];
                st[i] = t ^ ror64(t, ra[i][0]) ^ ror64(t, ra[i][1]);
            end
        end
    endtask

    task automatic model(input bit d, input int nad, input int ntxt);
        logic [127:0] c;
        st[0] = 64'h00001000808c0001;
        st[1] = key_m[63:0];   st[2] = key_m[127:64];
        st[3] = nonce_m[63:0]; st[4] = nonce_m[127:64];
        permute(12);
        st[3] ^= key_m[63:0]; st[4] ^= key_m[127:64];
        for (int i = 0; i < nad; i++) begin
            st[0] ^= blk_ad[i][63:0]; st[1] ^= blk_ad[i][127:64];
            permute(8);
        end
        if (nad > 0) begin
            st[0][0] = ~st[0][0];
            permute(8);
        end
        st[4][63] = ~st[4][63];
        for (int i = 0; i < ntxt; i++) begin
            c = {st[1], st[0]} ^ blk_tx[i];
            exp_out[i] = c;
            if (d) {st[1], st[0]} = blk_tx[i];
            else   {st[1], st[0]} = c;
            if (i < ntxt - 1) permute(8);
        end
        st[0][0] = ~st[0][0];
        st[2] ^= key_m[63:0]; st[3] ^= key_m[127:64];
        permute(12);
        exp_tag = {st[4], st[3]} ^ key_m;
    endtask

    function automatic int exp_lat(input int nad, input int ntxt);
        int l;
        l = (12 / UNROLL + 1) + 1 + 1 + 12 / UNROLL;
        l += nad * (1 + 8 / UNROLL) + ((nad > 0) ? 8 / UNROLL : 0);
        l += ntxt + ((ntxt > 0) ? (ntxt - 1) * (8 / UNROLL) : 0);
        return l;
    endfunction

    function automatic logic [127:0] blk_at(input int k, input int nad);
        return (k < nad) ? blk_ad[k] : blk_tx[k - nad];
    endfunction

    // ---------------- driver ----------------
    // mode 0: full rate; mode 1: random gaps/backpressure/stray starts; mode 2: 20-cycle stall
    task automatic run_op(input bit d, input int nad, input int ntxt, input int mode,
                          input logic [127:0] tin);
        int k, total, c, stall_left;
        bit armed;
        logic [127:0] held;
        total = nad + ntxt; k = 0; c = 0; armed = 0; stall_left = 20; held = '0;
        r_tmo = 0; r_stall_err = 0;
        got_q.delete();
        key = key_m; nonce = nonce_m; tag_in = tin; dec = d;
        has_ad = (nad > 0); has_text = (ntxt > 0);
        out_ready = (mode != 2);
        in_valid = (total > 0);
        in_data = (total > 0) ? blk_at(0, nad) : '0;
        in_last = (nad - 1 == 0) || (total - 1 == 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        forever begin
            @(negedge clk);
            if (done) begin
                r_tag = tag; r_tag_ok = tag_ok;
                break;
            end
            if (mode == 2) begin
                if (out_valid && !armed) begin armed = 1; held = out_data; end
                if (armed && stall_left > 0) begin
                    if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1)
                        r_stall_err++;
                    stall_left--;
                end
            end
            if (in_valid && in_ready) k++;
            if (c >= 3000) begin r_tmo = 1; break; end
            @(posedge clk); c++; #1;
            in_valid = (k < total) && (mode != 1 || $urandom_range(0, 9) < 7);
            in_data  = (k < total) ? blk_at(k, nad) : '0;
            in_last  = (k == nad - 1) || (k == total - 1);
            case (mode)
                1: begin
                    out_ready = ($urandom_range(0, 9) < 7);
                    start = ($urandom_range(0, 15) == 0);
                    dec = $urandom_range(0, 1);
                end
                2: out_ready = (stall_left == 0);
                default: out_ready = 1'b1;
            endcase
        end
        r_lat = c;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; dec = d;
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_assert++;
        if ({busy, done, out_valid, in_ready, tag_ok} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000",
                               {busy, done, out_valid, in_ready, tag_ok});
        end
        n_assert++;
        if (tag !== '0) begin n_fail++; $display("FAIL reset_tag: got %h expected 0", tag); end
        n_assert++;
        if (out_data !== '0) begin
            n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_kat_empty();
        key_m = 128'h000102030405060708090a0b0c0d0e0f;
        nonce_m = 128'h000102030405060708090a0b0c0d0e0f;
        model(0, 0, 0);
        run_op(0, 0, 0, 0, '0);
        n_assert++;
        if (r_tmo) begin n_fail++; $display("FAIL kat_timeout: no done within budget"); end
        n_assert++;
        if (r_tag !== exp_tag) begin
            n_fail++; $display("FAIL kat_tag: got %h expected %h", r_tag, exp_tag);
        end
        n_assert++;
        if (r_lat != exp_lat(0, 0)) begin
            n_fail++; $display("FAIL kat_latency: got %0d expected %0d", r_lat, exp_lat(0, 0));
        end
        n_assert++;
        if (got_q.size() != 0) begin
            n_fail++; $display("FAIL kat_out_count: got %0d expected 0", got_q.size());
        end
        n_assert++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL kat_busy_after: got %b expected 0", busy); end
    endtask

    logic [127:0] pt_save [8];
    logic [127:0] ct_save [8];
    logic [127:0] tag_save;

    task automatic test_enc_multi();
        key_m = rnd128(); nonce_m = rnd128();
        for (int i = 0; i < 2; i++) blk_ad[i] = rnd128();
        for (int i = 0; i < 3; i++) begin blk_tx[i] = rnd128(); pt_save[i] = blk_tx[i]; end
        model(0, 2, 3);
        run_op(0, 2, 3, 0, '0);
        n_assert++;
        if (got_q.size() != 3) begin
            n_fail++; $display("FAIL enc_out_count: got %0d expected 3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_assert++;
            if (got_q[i] !== exp_out[i]) begin
                n_fail++; $display("FAIL enc_ct%0d: got %h expected %h", i, got_q[i], exp_out[i]);
            end
            ct_save[i] = got_q[i];
        end
        n_assert++;
        if (r_tag !== exp_tag) begin
            n_fail++; $display("FAIL enc_tag: got %h expected %h", r_tag, exp_tag);
        end
        n_assert++;
        if (r_tag_ok !== 1'b0) begin n_fail++; $display("FAIL enc_tag_ok: got %b expected 0", r_tag_ok); end
        n_assert++;
        if (r_lat != exp_lat(2, 3)) begin
            n_fail++; $display("FAIL enc_latency: got %0d expected %0d", r_lat, exp_lat(2, 3));
        end
        tag_save = exp_tag;
    endtask

    task automatic test_dec();
        logic [127:0] bad;
        logic [127:0] exp_t;
        bit exp_ok;
        for (int i = 0; i < 3; i++) blk_tx[i] = ct_save[i];
        model(1, 2, 3);
        for (int pass = 0; pass < 2; pass++) begin
            bad = tag_save ^ ((pass == 1) ? 128'd1 : 128'd0);
            run_op(1, 2, 3, 0, bad);
            n_assert++;
            if (got_q.size() != 3) begin
                n_fail++; $display("FAIL dec_out_count: got %0d expected 3", got_q.size());
            end
            for (int i = 0; i < 3 && i < got_q.size(); i++) begin
                n_assert++;
                if (got_q[i] !== pt_save[i]) begin
                    n_fail++; $display("FAIL dec_pt%0d: got %h expected %h", i, got_q[i], pt_save[i]);
                end
            end
            exp_ok = 0; exp_t = tag_save;
`ifdef ASCON_TAG_VERIFY_EN
            exp_ok = (pass == 0);
            if (pass == 1) exp_t = '0;
`endif
            n_assert++;
            if (r_tag !== exp_t) begin
                n_fail++; $display("FAIL dec_tag pass%0d: got %h expected %h", pass, r_tag, exp_t);
            end
            n_assert++;
            if (r_tag_ok !== exp_ok) begin
                n_fail++; $display("FAIL dec_tag_ok pass%0d: got %b expected %b", pass, r_tag_ok, exp_ok);
            end
            n_assert++;
            if (r_lat != exp_lat(2, 3)) begin
                n_fail++; $display("FAIL dec_latency: got %0d expected %0d", r_lat, exp_lat(2, 3));
            end
        end
    endtask

    task automatic test_stall();
        key_m = rnd128(); nonce_m = rnd128();
        blk_ad[0] = rnd128();
        for (int i = 0; i < 3; i++) blk_tx[i] = rnd128();
        model(0, 1, 3);
        run_op(0, 1, 3, 2, '0);
        n_assert++;
        if (r_stall_err != 0) begin
            n_fail++; $display("FAIL stall_hold: got %0d bad cycles expected 0", r_stall_err);
        end
        n_assert++;
        if (got_q.size() != 3) begin
            n_fail++; $display("FAIL stall_out_count: got %0d expected 3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_assert++;
            if (got_q[i] !== exp_out[i]) begin
                n_fail++; $display("FAIL stall_ct%0d: got %h expected %h", i, got_q[i], exp_out[i]);
            end
        end
        n_assert++;
        if (r_tag !== exp_tag) begin
            n_fail++; $display("FAIL stall_tag: got %h expected %h", r_tag, exp_tag);
        end
    endtask

    task automatic test_back_to_back();
        int nad, ntxt;
        bit d, exp_ok;
        logic [127:0] tin, exp_t;
        for (int it = 0; it < 8; it++) begin
            key_m = rnd128(); nonce_m = rnd128();
            nad = $urandom_range(0, 3); ntxt = $urandom_range(0, 3); d = $urandom_range(0, 1);
            for (int i = 0; i < 3; i++) begin blk_ad[i] = rnd128(); blk_tx[i] = rnd128(); end
            model(d, nad, ntxt);
            tin = ($urandom_range(0, 1) == 1) ? exp_tag : rnd128();
            exp_ok = 0; exp_t = exp_tag;
`ifdef ASCON_TAG_VERIFY_EN
            if (d) begin
                exp_ok = (tin == exp_tag);
                if (!exp_ok) exp_t = '0;
            end
`endif
            run_op(d, nad, ntxt, 1, tin);
            n_assert++;
            if (r_tmo || got_q.size() != ntxt) begin
                n_fail++; $display("FAIL b2b%0d_out_count: got %0d expected %0d (timeout %0d)",
                                   it, got_q.size(), ntxt, r_tmo);
            end
            for (int i = 0; i < ntxt && i < got_q.size(); i++) begin
                n_assert++;
                if (got_q[i] !== exp_out[i]) begin
                    n_fail++; $display("FAIL b2b%0d_blk%0d: got %h expected %h",
                                       it, i, got_q[i], exp_out[i]);
                end
            end
            n_assert++;
            if (r_tag !== exp_t || r_tag_ok !== exp_ok) begin
                n_fail++; $display("FAIL b2b%0d_tag: got %h/%b expected %h/%b",
                                   it, r_tag, r_tag_ok, exp_t, exp_ok);
            end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        logic [127:0] kat_tag;
        key_m = rnd128(); nonce_m = rnd128();
        key = key_m; nonce = nonce_m; dec = 0; has_ad = 1; has_text = 1;
        in_valid = 1; in_data = rnd128(); in_last = 0; out_ready = 1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        c = 0;
        forever begin
            @(negedge clk);
            if ((in_valid && in_ready) || c > 100) break;
            @(posedge clk); #1; c++;
        end
        @(posedge clk); #1;
        in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        n_assert++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
        rst_n = 1'b0;
        #2;
        n_assert++;
        if ({busy, done, out_valid, in_ready} !== 4'b0) begin
            n_fail++; $display("FAIL midrst_flags: got %b expected 0000", {busy, done, out_valid, in_ready});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        key_m = 128'h000102030405060708090a0b0c0d0e0f;
        nonce_m = 128'h000102030405060708090a0b0c0d0e0f;
        model(0, 0, 0);
        kat_tag = exp_tag;
        run_op(0, 0, 0, 0, '0);
        n_assert++;
        if (r_tag !== kat_tag || r_lat != exp_lat(0, 0)) begin
            n_fail++; $display("FAIL midrst_kat: got %h lat %0d expected %h lat %0d",
                               r_tag, r_lat, kat_tag, exp_lat(0, 0));
        end
    endtask

    initial begin
        start = 0; dec = 0; has_ad = 0; has_text = 0; key = '0; nonce = '0;
        in_valid = 0; in_data = '0; in_last = 0; out_ready = 1; tag_in = '0;
        test_reset();
        test_kat_empty();
        test_enc_multi();
        test_dec();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
